// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package lc3_mem_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    HOLD
  } mem_state_t;

  // Memory-mapped device register addresses
  localparam word_t KBSR_ADDR = 16'hFE00;
  localparam word_t KBDR_ADDR = 16'hFE02;
  localparam word_t DSR_ADDR  = 16'hFE04;
  localparam word_t DDR_ADDR  = 16'hFE06;

  // Latency counter width; covers LATENCY up to 15
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// MAR/MDR side bus between the LC-3 datapath (master) and the memory responder (slave).
interface lc3_mem_ctrl_if;
  import lc3_mem_pkg::*;

  logic  mem_en;
  logic  mem_we;
  word_t addr;
  word_t wdata;
  word_t rdata;
  logic  mem_rdy;

  modport master (
    output mem_en,
    output mem_we,
    output addr,
    output wdata,
    input  rdata,
    input  mem_rdy
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  addr,
    input  wdata,
    output rdata,
    output mem_rdy
  );

endinterface

// File: rtl/lc3_ram_array.sv
// Single-port word RAM: synchronous write, combinational read, no reset.
module lc3_ram_array
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_idx,
  input  word_t             i_din,
  output word_t             o_dout
);

  localparam int unsigned Depth = 1 << ADDR_W;

  word_t r_mem [Depth];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_din;
    end
  end

  assign o_dout = r_mem[i_idx];

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory responder: services MAR/MDR requests from an internal RAM with a fixed
// latency and signals completion with a one-cycle mem_rdy pulse.
// Optional macro LC3_MMIO_EN adds keyboard/display device registers at 0xFE00-0xFE06.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  lc3_mem_ctrl_if.slave mem
`ifdef LC3_MMIO_EN
  ,
  input  logic          kbd_vld,
  input  logic [7:0]    kbd_char,
  output logic          dsp_vld,
  output logic [7:0]    dsp_char
`endif
);

  if (LATENCY == 0 || LATENCY > 15) begin : g_bad_latency
    $error("lc3_mem_ctrl: LATENCY must be in 1..15");
  end
  if (ADDR_W == 0 || ADDR_W > 15) begin : g_bad_addr_w
    $error("lc3_mem_ctrl: ADDR_W must be in 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  mem_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_enter_done;
  logic              r_rdy;
  word_t             r_rdata;

  logic [ADDR_W-1:0] r_idx;
  logic              r_we;
  word_t             r_wdata;

  logic              w_idle;
  logic [ADDR_W-1:0] w_req_idx;
  logic              w_req_we;
  word_t             w_req_wdata;
  logic              w_is_mmio;
  word_t             w_mmio_rd;
  word_t             w_ram_dout;
  logic              w_ram_we;
  word_t             w_rd_data;

  // In IDLE the live bus is the request (matters only when LATENCY=1 and DONE is
  // entered on the accepting edge); otherwise the frozen captured fields are used.
  assign w_idle      = (r_state == IDLE);
  assign w_req_idx   = w_idle ? mem.addr[ADDR_W-1:0] : r_idx;
  assign w_req_we    = w_idle ? mem.mem_we : r_we;
  assign w_req_wdata = w_idle ? mem.wdata : r_wdata;

  // Reset on the completing edge aborts the write as well as the pulse
  assign w_ram_we  = w_enter_done & w_req_we & ~w_is_mmio & ~rst;
  assign w_rd_data = w_is_mmio ? w_mmio_rd : w_ram_dout;

  lc3_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_idx  (w_req_idx),
    .i_din  (w_req_wdata),
    .o_dout (w_ram_dout)
  );

  // Next-state and latency counter
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (mem.mem_en) begin
          w_cnt_nxt = LAT_M1;
          if (LATENCY == 1) begin
            w_state_nxt  = DONE;
            w_enter_done = 1'b1;
          end else begin
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt  = DONE;
          w_enter_done = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = mem.mem_en ? HOLD : IDLE;
      end
      HOLD: begin
        if (!mem.mem_en) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counter, completion pulse and read-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdy   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rdy   <= w_enter_done;
      if (w_enter_done && !w_req_we) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  // Request capture on acceptance; held until the next accept
  always_ff @(posedge clk) begin
    if (w_idle && mem.mem_en) begin
      r_idx   <= mem.addr[ADDR_W-1:0];
      r_we    <= mem.mem_we;
      r_wdata <= mem.wdata;
    end
  end

  assign mem.rdata   = r_rdata;
  assign mem.mem_rdy = r_rdy;

`ifdef LC3_MMIO_EN
  word_t      r_addr;
  word_t      w_req_addr;
  logic       r_kbsr;
  logic [7:0] r_kbdr;
  logic       r_dsp_vld;
  logic [7:0] r_dsp_char;

  assign w_req_addr = w_idle ? mem.addr : r_addr;
  assign w_is_mmio  = (w_req_addr == KBSR_ADDR) || (w_req_addr == KBDR_ADDR) ||
                      (w_req_addr == DSR_ADDR)  || (w_req_addr == DDR_ADDR);

  // Device register read mux
  always_comb begin
    w_mmio_rd = '0;
    case (w_req_addr)
      KBSR_ADDR: w_mmio_rd = {r_kbsr, 15'b0};
      KBDR_ADDR: w_mmio_rd = {8'b0, r_kbdr};
      DSR_ADDR:  w_mmio_rd = 16'h8000;
      default:   w_mmio_rd = '0;
    endcase
  end

  // Full address capture for device decode
  always_ff @(posedge clk) begin
    if (w_idle && mem.mem_en) begin
      r_addr <= mem.addr;
    end
  end

  // Keyboard status/data and display output; a new key wins over a same-cycle KBDR read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kbsr     <= 1'b0;
      r_kbdr     <= '0;
      r_dsp_vld  <= 1'b0;
      r_dsp_char <= '0;
    end else begin
      if (kbd_vld) begin
        r_kbsr <= 1'b1;
        r_kbdr <= kbd_char;
      end else if (w_enter_done && !w_req_we && (w_req_addr == KBDR_ADDR)) begin
        r_kbsr <= 1'b0;
      end
      r_dsp_vld <= w_enter_done && w_req_we && (w_req_addr == DDR_ADDR);
      if (w_enter_done && w_req_we && (w_req_addr == DDR_ADDR)) begin
        r_dsp_char <= w_req_wdata[7:0];
      end
    end
  end

  assign dsp_vld  = r_dsp_vld;
  assign dsp_char = r_dsp_char;
`else
  logic w_unused_addr_hi;

  assign w_is_mmio        = 1'b0;
  assign w_mmio_rd        = '0;
  assign w_unused_addr_hi = ^mem.addr[15:ADDR_W];
`endif

endmodule
